// File: rtl/mem_loader.sv
// mem_loader: turns a framed byte stream into 16-bit word writes for the
// instruction or data memory, and issues the processor start pulse.
//
// Frames:
//   load  : HDR, ADDR_H, ADDR_L, CNT_H, CNT_L, CNT x (DATA_H, DATA_L)
//   start : HDR only
//   HDR 0xA5 = instruction memory, 0x5A = data memory, 0xC3 = start.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   rx_data, rx_valid   incoming byte; accepted when rx_valid && rx_ready
//   rx_ready            loader can take a byte (registered)
//   iram_wr_en          one-cycle instruction-memory write strobe
//   dram_wr_en          one-cycle data-memory write strobe
//   wr_addr, wr_data    write word address / data, held outside a write
//   start               one-cycle processor start pulse
//   busy                a frame is in progress
//   err                 sticky protocol error, cleared by a valid header
module mem_loader #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              iram_wr_en,
  output logic              dram_wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              start,
  output logic              busy,
  output logic              err
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [7:0]  HDR_IRAM  = 8'hA5;
  localparam logic [7:0]  HDR_DRAM  = 8'h5A;
  localparam logic [7:0]  HDR_START = 8'hC3;
  // Address bits that must be zero for the target memory.
  localparam logic [15:0] ADDR_HI_MASK = 16'hFFFF << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_H,
    S_ADDR_L,
    S_CNT_H,
    S_CNT_L,
    S_DATA_H,
    S_DATA_L,
    S_WRITE
  } state_t;

  state_t              state_q;
  state_t              next_state;
  logic [7:0]          addr_h_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          cnt_h_q;
  logic [15:0]         cnt_rem_q;
  logic [7:0]          data_h_q;
  logic                is_iram_q;
  logic [TMO_W-1:0]    tmo_q;

  logic                accept;
  logic [15:0]         full_addr;
  logic [15:0]         full_cnt;
  logic                tmo_hit;
  logic                in_frame;
  logic                set_err;
  logic                clr_err;
  logic                fire_start;
  logic                load_write;

  assign accept    = rx_valid & rx_ready;
  assign full_addr = {addr_h_q, rx_data};
  assign full_cnt  = {cnt_h_q, rx_data};
  assign tmo_hit   = (tmo_q == TMO_W'(TIMEOUT - 1));
  // States in which the inter-byte timeout runs.
  assign in_frame  = (state_q != S_IDLE) && (state_q != S_WRITE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  // Next-state and control decode.
  always_comb begin
    next_state = state_q;
    set_err    = 1'b0;
    clr_err    = 1'b0;
    fire_start = 1'b0;
    load_write = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (rx_data)
            HDR_IRAM, HDR_DRAM: begin
              clr_err    = 1'b1;
              next_state = S_ADDR_H;
            end
            HDR_START: begin
              clr_err    = 1'b1;
              fire_start = 1'b1;
            end
            default: set_err = 1'b1;
          endcase
        end
      end
      S_ADDR_H: if (accept) next_state = S_ADDR_L;
      S_ADDR_L: begin
        if (accept) begin
          if ((full_addr & ADDR_HI_MASK) != 16'd0) begin
            set_err    = 1'b1;
            next_state = S_IDLE;
          end else begin
            next_state = S_CNT_H;
          end
        end
      end
      S_CNT_H: if (accept) next_state = S_CNT_L;
      S_CNT_L: begin
        if (accept) begin
          next_state = (full_cnt == 16'd0) ? S_IDLE : S_DATA_H;
        end
      end
      S_DATA_H: if (accept) next_state = S_DATA_L;
      S_DATA_L: begin
        if (accept) begin
          load_write = 1'b1;
          next_state = S_WRITE;
        end
      end
      S_WRITE: begin
        next_state = (cnt_rem_q == 16'd1) ? S_IDLE : S_DATA_H;
      end
      default: next_state = S_IDLE;
    endcase

    // A stalled frame is abandoned; any half-received word is dropped.
    if (in_frame && !accept && tmo_hit) begin
      next_state = S_IDLE;
      set_err    = 1'b1;
      load_write = 1'b0;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ready   <= 1'b0;
      busy       <= 1'b0;
      start      <= 1'b0;
      iram_wr_en <= 1'b0;
      dram_wr_en <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 16'd0;
      err        <= 1'b0;
    end else begin
      rx_ready   <= (next_state != S_WRITE);
      busy       <= (next_state != S_IDLE);
      start      <= fire_start;
      iram_wr_en <= load_write & is_iram_q;
      dram_wr_en <= load_write & ~is_iram_q;
      if (load_write) begin
        wr_addr <= addr_q;
        wr_data <= {data_h_q, rx_data};
      end
      if (set_err) begin
        err <= 1'b1;
      end else if (clr_err) begin
        err <= 1'b0;
      end
    end
  end

  // Frame field capture, address/count stepping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_h_q  <= 8'd0;
      addr_q    <= '0;
      cnt_h_q   <= 8'd0;
      cnt_rem_q <= 16'd0;
      data_h_q  <= 8'd0;
      is_iram_q <= 1'b0;
    end else begin
      if (accept) begin
        case (state_q)
          S_IDLE: begin
            if (rx_data == HDR_IRAM || rx_data == HDR_DRAM) begin
              is_iram_q <= (rx_data == HDR_IRAM);
            end
          end
          S_ADDR_H: addr_h_q  <= rx_data;
          S_ADDR_L: addr_q    <= full_addr[ADDR_W-1:0];
          S_CNT_H:  cnt_h_q   <= rx_data;
          S_CNT_L:  cnt_rem_q <= full_cnt;
          S_DATA_H: data_h_q  <= rx_data;
          default: ;
        endcase
      end
      // Address wraps naturally at the memory size.
      if (state_q == S_WRITE) begin
        addr_q    <= addr_q + ADDR_W'(1);
        cnt_rem_q <= cnt_rem_q - 16'd1;
      end
    end
  end

  // Inter-byte idle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else if (accept || !in_frame || next_state == S_IDLE) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TMO_W'(1);
    end
  end

endmodule
